writeback_stage: RTL and testbench



---
 rtl/writeback_stage.sv | 141 ++++++++++++++
 tb/tb_writeback_stage.sv | 198 +++++++++++++++++++
 2 files changed

// File: rtl/writeback_stage.sv
// Writeback stage: result select, load alignment/extension, one-entry output register held until the RF write port accepts.
// Optional retired-instruction counter enabled by defining WB_RETIRE_COUNT_EN.
module writeback_stage #(
    parameter int CORE           = 0,
    parameter int DATA_WIDTH     = 32,
    parameter int REG_ADDR_WIDTH = 5
) (
    input  logic                      clk_i,
    input  logic                      srst_i,
    input  logic                      in_valid_i,
    output logic                      in_ready_o,
    input  logic                      in_write_i,
    input  logic [1:0]                in_sel_i,
    input  logic [REG_ADDR_WIDTH-1:0] in_reg_i,
    input  logic [DATA_WIDTH-1:0]     in_alu_i,
    input  logic [DATA_WIDTH-1:0]     in_mem_i,
    input  logic [DATA_WIDTH-1:0]     in_link_i,
    input  logic [DATA_WIDTH-1:0]     in_csr_i,
    input  logic [1:0]                in_size_i,
    input  logic                      in_unsigned_i,
    input  logic [1:0]                in_byte_off_i,
    input  logic                      rf_ready_i,
    output logic                      write_o,
    output logic [REG_ADDR_WIDTH-1:0] write_reg_o,
    output logic [DATA_WIDTH-1:0]     write_data_o,
`ifdef WB_RETIRE_COUNT_EN
    output logic [31:0]               retired_count_o,
`endif
    output logic                      misaligned_o
);

    if (DATA_WIDTH < 32 || CORE < 0) begin : g_bad_param
        $error("writeback_stage: DATA_WIDTH must be >= 32 and CORE non-negative");
    end

    logic                      out_valid_q;
    logic                      out_write_q;
    logic [REG_ADDR_WIDTH-1:0] out_reg_q;
    logic [DATA_WIDTH-1:0]     out_data_q;
    logic                      out_mis_q;

    logic [DATA_WIDTH-1:0]     data_d;
    logic                      mis_d;
    logic [DATA_WIDTH-1:0]     load_ext;
    logic [7:0]                mem_bytes [4];
    logic [15:0]               mem_half;
    logic                      load_sign;

    logic need_rf;
    logic retire;
    logic accept;

    genvar gi;
    for (gi = 0; gi < 4; gi++) begin : g_lane
        assign mem_bytes[gi] = in_mem_i[8*gi +: 8];
    end

    assign mem_half = in_byte_off_i[1] ? in_mem_i[31:16] : in_mem_i[15:0];

    // Fill with the sign (or zero) first, then overlay the selected low bits.
    always_comb begin
        load_sign = 1'b0;
        load_ext  = '0;
        case (in_size_i)
            2'b00: begin
                load_sign     = mem_bytes[in_byte_off_i][7] & ~in_unsigned_i;
                load_ext      = {DATA_WIDTH{load_sign}};
                load_ext[7:0] = mem_bytes[in_byte_off_i];
            end
            2'b01: begin
                load_sign      = mem_half[15] & ~in_unsigned_i;
                load_ext       = {DATA_WIDTH{load_sign}};
                load_ext[15:0] = mem_half;
            end
            default: begin
                load_sign      = in_mem_i[31] & ~in_unsigned_i;
                load_ext       = {DATA_WIDTH{load_sign}};
                load_ext[31:0] = in_mem_i[31:0];
            end
        endcase
    end

    always_comb begin
        data_d = in_alu_i;
        mis_d  = 1'b0;
        case (in_sel_i)
            2'b00: data_d = in_alu_i;
            2'b01: begin
                data_d = load_ext;
                mis_d  = ((in_size_i == 2'b01) && in_byte_off_i[0]) ||
                         (in_size_i[1] && (in_byte_off_i != 2'b00));
            end
            2'b10: data_d = in_link_i;
            default: data_d = in_csr_i;
        endcase
    end

    // Entries that cannot write (x0, misaligned, no-write) retire without the RF port.
    assign need_rf    = out_write_q && (out_reg_q != '0) && !out_mis_q;
    assign retire     = out_valid_q && (rf_ready_i || !need_rf);
    assign in_ready_o = srst_i || !out_valid_q || retire;
    assign accept     = in_valid_i && in_ready_o && !srst_i;

    always_ff @(posedge clk_i) begin
        if (srst_i) begin
            out_valid_q <= 1'b0;
            out_write_q <= 1'b0;
            out_reg_q   <= '0;
            out_data_q  <= '0;
            out_mis_q   <= 1'b0;
        end else if (accept) begin
            out_valid_q <= 1'b1;
            out_write_q <= in_write_i;
            out_reg_q   <= in_reg_i;
            out_data_q  <= data_d;
            out_mis_q   <= mis_d;
        end else if (retire) begin
            out_valid_q <= 1'b0;
        end
    end

`ifdef WB_RETIRE_COUNT_EN
    logic [31:0] retired_count_q;

    always_ff @(posedge clk_i) begin
        if (srst_i) begin
            retired_count_q <= '0;
        end else if (retire) begin
            retired_count_q <= retired_count_q + 32'd1;
        end
    end

    assign retired_count_o = retired_count_q;
`endif

    assign write_o      = out_valid_q && need_rf && !srst_i;
    assign write_reg_o  = out_reg_q;
    assign write_data_o = out_data_q;
    assign misaligned_o = out_valid_q && out_mis_q;

endmodule

// File: tb/tb_writeback_stage.sv
// Directed and randomized checks of writeback_stage against a transaction-level reference model.
module tb_writeback_stage;

    logic        clk = 1'b0;
    logic        srst;
    logic        in_valid, in_write, in_unsigned, rf_ready;
    logic [1:0]  in_sel, in_size, in_byte_off;
    logic [4:0]  in_reg;
    logic [31:0] in_alu, in_mem, in_link, in_csr;
    logic        in_ready, write_en, misaligned;
    logic [4:0]  write_reg;
    logic [31:0] write_data;
`ifdef WB_RETIRE_COUNT_EN
    logic [31:0] retired_count;
`endif

    int checks   = 0;
    int failures = 0;

    // Reference model: the one held instruction, described by what it should do.
    logic        m_valid = 1'b0;
    logic        m_wr    = 1'b0;
    logic [4:0]  m_reg   = '0;
    logic [31:0] m_data  = '0;
    logic        m_mis   = 1'b0;
    logic [31:0] m_cnt   = '0;

    always #5 clk = ~clk;

    writeback_stage #(.CORE(0), .DATA_WIDTH(32), .REG_ADDR_WIDTH(5)) dut (
        .clk_i          (clk),
        .srst_i         (srst),
        .in_valid_i     (in_valid),
        .in_ready_o     (in_ready),
        .in_write_i     (in_write),
        .in_sel_i       (in_sel),
        .in_reg_i       (in_reg),
        .in_alu_i       (in_alu),
        .in_mem_i       (in_mem),
        .in_link_i      (in_link),
        .in_csr_i       (in_csr),
        .in_size_i      (in_size),
        .in_unsigned_i  (in_unsigned),
        .in_byte_off_i  (in_byte_off),
        .rf_ready_i     (rf_ready),
        .write_o        (write_en),
        .write_reg_o    (write_reg),
        .write_data_o   (write_data),
`ifdef WB_RETIRE_COUNT_EN
        .retired_count_o(retired_count),
`endif
        .misaligned_o   (misaligned)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Load value as the memory would deliver it: shift, mask to size, then extend.
    function automatic logic [31:0] load_value(input logic [31:0] mem, input logic [1:0] size,
                                               input logic uns, input logic [1:0] off);
        int unsigned nbytes;
        int unsigned shift;
        longint      v;
        nbytes = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
        shift  = (size == 2'd0) ? 8 * int'(off) : (size == 2'd1) ? (off[1] ? 16 : 0) : 0;
        v = longint'((64'(mem) >> shift) & ((64'd1 << (8 * nbytes)) - 64'd1));
        if (!uns && v >= (longint'(1) << (8 * nbytes - 1)))
            v = v - (longint'(1) << (8 * nbytes));
        return v[31:0];
    endfunction

    function automatic logic model_writes();
        return m_valid && m_wr && (m_reg != 5'd0) && !m_mis;
    endfunction

    // One clock cycle: check registered outputs, drive inputs, check combinational outputs, advance model.
    task automatic step(input logic rst, input logic iv, input logic iw, input logic [1:0] sel,
                        input logic [4:0] rg, input logic [31:0] alu, input logic [31:0] mem,
                        input logic [31:0] link, input logic [31:0] csr, input logic [1:0] size,
                        input logic uns, input logic [1:0] off, input logic rf);
        logic        retire_m, ready_m, is_load;
        int unsigned nbytes;
        chk("write_reg", 32'(write_reg), 32'(m_reg));
        chk("write_data", write_data, m_data);
        chk("misaligned", 32'(misaligned), 32'(m_valid && m_mis));
`ifdef WB_RETIRE_COUNT_EN
        chk("retired_count", retired_count, m_cnt);
`endif
        srst = rst; in_valid = iv; in_write = iw; in_sel = sel; in_reg = rg;
        in_alu = alu; in_mem = mem; in_link = link; in_csr = csr;
        in_size = size; in_unsigned = uns; in_byte_off = off; rf_ready = rf;
        #1;
        retire_m = m_valid && (rf || !model_writes());
        ready_m  = rst || !m_valid || retire_m;
        chk("in_ready", 32'(in_ready), 32'(ready_m));
        chk("write", 32'(write_en), 32'(model_writes() && !rst));
        if (rst) begin
            m_valid = 0; m_wr = 0; m_reg = '0; m_data = '0; m_mis = 0; m_cnt = '0;
        end else begin
            if (retire_m) m_cnt = m_cnt + 32'd1;
            if (iv && ready_m) begin
                is_load = (sel == 2'b01);
                nbytes  = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
                m_valid = 1; m_wr = iw; m_reg = rg;
                m_mis   = is_load && ((int'(off) % nbytes) != 0);
                case (sel)
                    2'b00:   m_data = alu;
                    2'b01:   m_data = load_value(mem, size, uns, off);
                    2'b10:   m_data = link;
                    default: m_data = csr;
                endcase
            end else if (retire_m) begin
                m_valid = 0;
            end
        end
        @(negedge clk);
    endtask

    task automatic alu_step(input logic iv, input logic [4:0] rg, input logic [31:0] v, input logic rf);
        step(0, iv, 1, 2'b00, rg, v, 32'h0, 32'h0, 32'h0, 2'b10, 0, 2'b00, rf);
    endtask

    task automatic load_step(input logic [4:0] rg, input logic [31:0] mem, input logic [1:0] size,
                             input logic uns, input logic [1:0] off);
        step(0, 1, 1, 2'b01, rg, 32'h0, mem, 32'h0, 32'h0, size, uns, off, 1);
    endtask

    initial begin
        @(negedge clk);
        step(1, 0, 0, 2'b00, 5'd0, 0, 0, 0, 0, 2'b00, 0, 2'b00, 0);
        step(1, 1, 1, 2'b00, 5'd3, 32'hDEAD, 0, 0, 0, 2'b00, 0, 2'b00, 1);
        chk("reset_write", 32'(write_en), 32'h0);
        chk("reset_data", write_data, 32'h0);

        // ALU pass-through, then back-to-back accepts.
        alu_step(1, 5'd5, 32'h1234, 1);
        chk("alu_write", 32'(write_en), 32'h1);
        chk("alu_reg", 32'(write_reg), 32'd5);
        chk("alu_data", write_data, 32'h1234);
        alu_step(1, 5'd6, 32'h5678, 1);
        chk("b2b_ready", 32'(in_ready), 32'h1);
        alu_step(1, 5'd7, 32'h9ABC, 1);
        chk("b2b_data", write_data, 32'h9ABC);

        // Load formatting.
        load_step(5'd8, 32'h80FF7F01, 2'b00, 0, 2'd3);
        chk("lb_signed", write_data, 32'hFFFFFF80);
        load_step(5'd8, 32'h80FF7F01, 2'b00, 1, 2'd3);
        chk("lb_unsigned", write_data, 32'h00000080);
        load_step(5'd8, 32'h80FF7F01, 2'b01, 0, 2'd2);
        chk("lh_signed", write_data, 32'hFFFF80FF);

        // Misaligned half retires without writing.
        load_step(5'd9, 32'h80FF7F01, 2'b01, 0, 2'd1);
        chk("mis_flag", 32'(misaligned), 32'h1);
        chk("mis_write", 32'(write_en), 32'h0);
        alu_step(0, 5'd0, 32'h0, 0);
        chk("mis_empty", 32'(misaligned), 32'h0);

        // Back-pressure: held entry stays stable for three stalled cycles.
        alu_step(1, 5'd10, 32'hAAAA, 1);
        for (int i = 0; i < 3; i++) begin
            alu_step(1, 5'd11, 32'hBBBB, 0);
            chk("stall_data", write_data, 32'hAAAA);
        end
        alu_step(1, 5'd11, 32'hBBBB, 1);
        chk("resume_data", write_data, 32'hBBBB);

        // x0 write retires without rf_ready.
        step(0, 1, 1, 2'b00, 5'd0, 32'h77, 0, 0, 0, 2'b00, 0, 2'b00, 1);
        chk("x0_write", 32'(write_en), 32'h0);
        alu_step(0, 5'd0, 32'h0, 0);

        // Reset during a stall drops the entry.
        alu_step(1, 5'd12, 32'hCCCC, 0);
        alu_step(0, 5'd0, 32'h0, 0);
        step(1, 0, 0, 2'b00, 5'd0, 0, 0, 0, 0, 2'b00, 0, 2'b00, 0);
        chk("rst_stall_write", 32'(write_en), 32'h0);

        // Randomized traffic covering all sources, sizes and offsets.
        for (int i = 0; i < 500; i++) begin
            step(($urandom_range(0, 59) == 0), ($urandom_range(0, 3) != 0), $urandom_range(0, 1),
                 2'($urandom_range(0, 3)), ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom),
                 $urandom, $urandom, $urandom, $urandom, 2'($urandom_range(0, 3)),
                 $urandom_range(0, 1), 2'($urandom_range(0, 3)), ($urandom_range(0, 2) != 0));
        end
        step(0, 0, 0, 2'b00, 5'd0, 0, 0, 0, 0, 2'b00, 0, 2'b00, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
